// File: rtl/axi_default_slave_pkg.sv
// Shared AXI widths and response encodings, plus the package view of them
// used by the default slave and its bench.

`ifndef AXI_DEFINE_SVH
`define AXI_DEFINE_SVH
`define AXI_ID_BITS     4
`define AXI_LEN_BITS    4
`define AXI_DATA_BITS   32
`define AXI_RESP_OKAY   2'b00
`define AXI_RESP_EXOKAY 2'b01
`define AXI_RESP_SLVERR 2'b10
`define AXI_RESP_DECERR 2'b11
`endif

package axi_default_slave_pkg;

    localparam int AXI_ID_BITS   = `AXI_ID_BITS;
    localparam int AXI_LEN_BITS  = `AXI_LEN_BITS;
    localparam int AXI_DATA_BITS = `AXI_DATA_BITS;

    typedef enum logic [1:0] {
        RESP_OKAY   = `AXI_RESP_OKAY,
        RESP_EXOKAY = `AXI_RESP_EXOKAY,
        RESP_SLVERR = `AXI_RESP_SLVERR,
        RESP_DECERR = `AXI_RESP_DECERR
    } axi_resp_e;

endpackage

// File: rtl/axi_default_slave.sv
// Default AXI responder: accepts every transaction that decodes to no mapped
// slave and completes it with DEFAULT_RESP. Writes are swallowed, reads
// return READ_FILL for ARLEN+1 beats. One outstanding transaction per
// direction; read and write sides are independent.

module axi_default_slave
    import axi_default_slave_pkg::*;
#(
    parameter logic [1:0]               DEFAULT_RESP = RESP_DECERR,
    parameter logic [AXI_DATA_BITS-1:0] READ_FILL    = '0
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    // write address
    input  logic [AXI_ID_BITS-1:0]    AWID,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    // write data
    input  logic                      WLAST,
    input  logic                      WVALID,
    output logic                      WREADY,
    // write response
    output logic [AXI_ID_BITS-1:0]    BID,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    // read address
    input  logic [AXI_ID_BITS-1:0]    ARID,
    input  logic [AXI_LEN_BITS-1:0]   ARLEN,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    // read data
    output logic [AXI_ID_BITS-1:0]    RID,
    output logic [AXI_DATA_BITS-1:0]  RDATA,
    output logic [1:0]                RRESP,
    output logic                      RLAST,
    output logic                      RVALID,
    input  logic                      RREADY
);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    logic [1:0]              w_state;
    logic [0:0]              r_state;
    logic                    active;
    logic [AXI_ID_BITS-1:0]  w_id;
    logic [AXI_ID_BITS-1:0]  r_id;
    logic [AXI_LEN_BITS-1:0] r_len;
    logic [AXI_LEN_BITS-1:0] r_cnt;

    // Address readies stay low for the whole reset and rise one cycle after
    // release, so no handshake can land on the reset boundary.
    always_ff @(posedge ACLK) begin
        // NOTE: state registers use non-blocking assignments so every
        // always_ff sees the pre-edge values of the others.
        if (ARESET) active <= 1'b0;
        else        active <= 1'b1;
    end

    // Write FSM: take AW, sink W beats until WLAST, then present B.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state <= W_IDLE;
            w_id    <= '0;
        end else begin
            case (w_state)
                W_IDLE: if (AWVALID && AWREADY) begin
                    w_id    <= AWID;
                    w_state <= W_DATA;
                end
                W_DATA: if (WVALID && WLAST) w_state <= W_RESP;
                W_RESP: if (BREADY)          w_state <= W_IDLE;
                default:                     w_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM: take AR, then stream ARLEN+1 fill beats with RLAST on the final one.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (ARVALID && ARREADY) begin
                    r_id    <= ARID;
                    r_len   <= ARLEN;
                    r_cnt   <= '0;
                    r_state <= R_DATA;
                end
                R_DATA: if (RREADY) begin
                    if (r_cnt == r_len) r_state <= R_IDLE;
                    else                r_cnt   <= r_cnt + 1'b1;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Write-side outputs decode state and captured ID only.
    assign AWREADY = active && (w_state == W_IDLE);
    assign WREADY  = (w_state == W_DATA);
    assign BVALID  = (w_state == W_RESP);
    assign BID     = BVALID ? w_id : '0;
    assign BRESP   = BVALID ? DEFAULT_RESP : 2'b00;

    // Read-side outputs decode state, captured ID/length and the beat counter.
    assign ARREADY = active && (r_state == R_IDLE);
    assign RVALID  = (r_state == R_DATA);
    assign RID     = RVALID ? r_id : '0;
    assign RDATA   = RVALID ? READ_FILL : '0;
    assign RRESP   = RVALID ? DEFAULT_RESP : 2'b00;
    assign RLAST   = RVALID && (r_cnt == r_len);

endmodule

// File: tb/tb_axi_default_slave.sv
// Bench for axi_default_slave: directed scenarios plus randomized bursts,
// each checked against a beat-counting transaction model.

module tb_axi_default_slave;
    import axi_default_slave_pkg::*;

    localparam logic [1:0]               EXP_RESP = 2'b11;
    localparam logic [AXI_DATA_BITS-1:0] EXP_FILL = '0;

    logic                     ACLK = 1'b0;
    logic                     ARESET;
    logic [AXI_ID_BITS-1:0]   AWID;
    logic                     AWVALID;
    logic                     AWREADY;
    logic                     WLAST;
    logic                     WVALID;
    logic                     WREADY;
    logic [AXI_ID_BITS-1:0]   BID;
    logic [1:0]               BRESP;
    logic                     BVALID;
    logic                     BREADY;
    logic [AXI_ID_BITS-1:0]   ARID;
    logic [AXI_LEN_BITS-1:0]  ARLEN;
    logic                     ARVALID;
    logic                     ARREADY;
    logic [AXI_ID_BITS-1:0]   RID;
    logic [AXI_DATA_BITS-1:0] RDATA;
    logic [1:0]               RRESP;
    logic                     RLAST;
    logic                     RVALID;
    logic                     RREADY;

    int n_checks = 0;
    int n_errors = 0;

    axi_default_slave dut (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .AWID    (AWID),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WLAST   (WLAST),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BID     (BID),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .ARID    (ARID),
        .ARLEN   (ARLEN),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RID     (RID),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RLAST   (RLAST),
        .RVALID  (RVALID),
        .RREADY  (RREADY)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; outputs are stable there.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // One write transaction: AW, `beats` W beats with random gaps, B after b_delay stalls.
    task automatic do_write(input logic [AXI_ID_BITS-1:0] id, input int beats,
                            input int gap_max, input int b_delay);
        AWID = id; AWVALID = 1'b1;
        check("wr_awready_idle", AWREADY, 1);
        check("wr_wready_idle", WREADY, 0);
        tick();
        AWVALID = 1'b0; AWID = '0;
        check("wr_wready_after_aw", WREADY, 1);
        check("wr_awready_busy", AWREADY, 0);
        for (int i = 0; i < beats; i++) begin
            int gaps = $urandom_range(gap_max, 0);
            WVALID = 1'b0;
            for (int g = 0; g < gaps; g++) begin
                tick();
                check("wr_wready_gap", WREADY, 1);
            end
            check("wr_bvalid_early", BVALID, 0);
            WVALID = 1'b1; WLAST = (i == beats - 1);
            tick();
        end
        WVALID = 1'b0; WLAST = 1'b0;
        check("wr_wready_after_last", WREADY, 0);
        for (int d = 0; d < b_delay; d++) begin
            check("wr_bvalid_held", BVALID, 1);
            check("wr_bid_held", BID, id);
            tick();
        end
        check("wr_bvalid", BVALID, 1);
        check("wr_bid", BID, id);
        check("wr_bresp", BRESP, EXP_RESP);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        check("wr_bvalid_done", BVALID, 0);
        check("wr_awready_done", AWREADY, 1);
    endtask

    // One read burst. mode 0: RREADY=1, 1: random, 2: RREADY from pat (LSB first).
    task automatic do_read(input logic [AXI_ID_BITS-1:0] id, input logic [AXI_LEN_BITS-1:0] len,
                           input int mode, input logic [31:0] pat);
        int beats = 0;
        int cyc   = 0;
        int n_exp = int'(len) + 1;
        logic rdy;
        ARID = id; ARLEN = len; ARVALID = 1'b1;
        check("rd_arready_idle", ARREADY, 1);
        check("rd_rvalid_idle", RVALID, 0);
        tick();
        ARVALID = 1'b0;
        while (beats < n_exp && cyc < 400) begin
            check("rd_rvalid", RVALID, 1);
            check("rd_rlast", RLAST, beats == n_exp - 1);
            check("rd_rid", RID, id);
            check("rd_rdata", RDATA, EXP_FILL);
            check("rd_rresp", RRESP, EXP_RESP);
            check("rd_arready_busy", ARREADY, 0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(1, 0));
                default: rdy = pat[cyc % 32];
            endcase
            RREADY = rdy;
            tick();
            if (rdy) beats++;
            cyc++;
        end
        RREADY = 1'b0;
        check("rd_beat_count", beats, n_exp);
        check("rd_rvalid_done", RVALID, 0);
        check("rd_arready_done", ARREADY, 1);
    endtask

    initial begin
        ARESET = 1'b1;
        AWID = '0; AWVALID = 1'b0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARLEN = '0; ARVALID = 1'b0; RREADY = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_awready", AWREADY, 0);
        check("rst_wready", WREADY, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_arready", ARREADY, 0);
        check("rst_rvalid", RVALID, 0);
        check("rst_rlast", RLAST, 0);
        check("rst_bid", BID, 0);
        check("rst_rid", RID, 0);
        check("rst_rdata", RDATA, 0);
        check("rst_rresp", RRESP, 0);
        ARESET = 1'b0;
        tick();
        check("rel_awready", AWREADY, 1);
        check("rel_arready", ARREADY, 1);

        // Directed: single-beat write, 4-beat read, backpressured read, max-length read
        do_write(4'h3, 1, 0, 0);
        do_read(4'h5, 4'd3, 0, 32'h0);
        do_read(4'h9, 4'd2, 2, 32'b11001);
        do_read(4'hA, 4'hF, 0, 32'h0);

        // W presented before AW is stalled until the AW handshake
        WVALID = 1'b1; WLAST = 1'b1;
        tick();
        check("wfirst_stall0", WREADY, 0);
        tick();
        check("wfirst_stall1", WREADY, 0);
        AWID = 4'hC; AWVALID = 1'b1;
        check("wfirst_stall_aw_cycle", WREADY, 0);
        tick();
        AWVALID = 1'b0;
        check("wfirst_wready", WREADY, 1);
        tick();
        WVALID = 1'b0; WLAST = 1'b0;
        check("wfirst_bvalid", BVALID, 1);
        check("wfirst_bid", BID, 4'hC);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        check("wfirst_done", BVALID, 0);

        // AW and AR in the same cycle, completed concurrently
        AWID = 4'h6; AWVALID = 1'b1; ARID = 4'h2; ARLEN = 4'd1; ARVALID = 1'b1;
        tick();
        AWVALID = 1'b0; ARVALID = 1'b0;
        check("conc_wready", WREADY, 1);
        check("conc_rvalid", RVALID, 1);
        check("conc_rid", RID, 4'h2);
        check("conc_rlast0", RLAST, 0);
        WVALID = 1'b1; WLAST = 1'b1; RREADY = 1'b1;
        tick();
        WVALID = 1'b0; WLAST = 1'b0;
        check("conc_bvalid", BVALID, 1);
        check("conc_bid", BID, 4'h6);
        check("conc_rvalid1", RVALID, 1);
        check("conc_rlast1", RLAST, 1);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0; RREADY = 1'b0;
        check("conc_bdone", BVALID, 0);
        check("conc_rdone", RVALID, 0);
        check("conc_awready", AWREADY, 1);
        check("conc_arready", ARREADY, 1);

        // Randomized traffic
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(1, 0) == 1)
                do_write(AXI_ID_BITS'($urandom), $urandom_range(4, 1), 2, $urandom_range(3, 0));
            else
                do_read(AXI_ID_BITS'($urandom), AXI_LEN_BITS'($urandom), 1, 32'h0);
        end

        // Reset mid-burst with a pending B
        AWID = 4'h5; AWVALID = 1'b1; ARID = 4'h7; ARLEN = 4'd3; ARVALID = 1'b1;
        tick();
        AWVALID = 1'b0; ARVALID = 1'b0;
        WVALID = 1'b1; WLAST = 1'b1; RREADY = 1'b1;
        tick();
        WVALID = 1'b0; WLAST = 1'b0;
        tick();
        check("mid_bvalid_pending", BVALID, 1);
        check("mid_rvalid_beat2", RVALID, 1);
        check("mid_rlast_beat2", RLAST, 0);
        ARESET = 1'b1;
        tick();
        check("mid_rst_rvalid", RVALID, 0);
        check("mid_rst_bvalid", BVALID, 0);
        check("mid_rst_rlast", RLAST, 0);
        check("mid_rst_arready", ARREADY, 0);
        ARESET = 1'b0;
        tick();
        check("mid_rel_arready", ARREADY, 1);
        check("mid_rel_awready", AWREADY, 1);
        check("mid_rel_rvalid", RVALID, 0);
        check("mid_rel_bvalid", BVALID, 0);
        tick();
        check("mid_no_stale_beat", RVALID, 0);
        check("mid_no_stale_rid", RID, 0);
        RREADY = 1'b0;

        // Still fully functional after the abandoned burst
        do_read(4'h1, 4'd0, 0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
